// File: rtl/slug_arb_pkg.sv
// Shared types and constants for the sprite ROM arbiter.
package slug_arb_pkg;

    localparam int NUM_REQ   = 3;
    localparam int PAL_IDX_W = 5;
    localparam int AGE_W     = 4;

    typedef enum logic [1:0] {
        REQ_PLAYER  = 2'd0,
        REQ_PLANE   = 2'd1,
        REQ_MISSILE = 2'd2
    } req_id_t;

    typedef struct packed {
        logic                 valid;
        req_id_t              id;
        logic [PAL_IDX_W-1:0] index;
    } rsp_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } arb_state_t;

endpackage

// File: rtl/sprite_rom_arbiter_if.sv
// Requester / ROM / response bus of the sprite ROM arbiter.
// master: requesters plus ROM side; slave: the arbiter.
interface sprite_rom_arbiter_if
    import slug_arb_pkg::*;
#(
    parameter int ADDR_W = 16
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0]        gnt;
    logic [ADDR_W-1:0]         rom_addr;
    logic [PAL_IDX_W-1:0]      rom_data;
    logic                      rsp_valid;
    logic [1:0]                rsp_id;
    logic [PAL_IDX_W-1:0]      rsp_index;

    modport master (
        output req, req_addr, rom_data,
        input  gnt, rom_addr, rsp_valid, rsp_id, rsp_index
    );

    modport slave (
        input  req, req_addr, rom_data,
        output gnt, rom_addr, rsp_valid, rsp_id, rsp_index
    );
endinterface

// File: rtl/sprite_arb_pick.sv
// Combinational selector: lowest-ID aged requester first, else lowest-ID requester.
module sprite_arb_pick
    import slug_arb_pkg::*;
#(
    parameter int AGE_MAX = 7
) (
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0][AGE_W-1:0] age,
    output logic [NUM_REQ-1:0]            gnt,
    output req_id_t                       win_id,
    output logic                          aged
);

    localparam logic [AGE_W-1:0] AGE_LIM = AGE_W'(AGE_MAX);

    logic [NUM_REQ-1:0] aged_vec;

    // a requester only counts as aged while it is still requesting
    always_comb begin
        aged_vec = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            aged_vec[i] = req[i] && (age[i] >= AGE_LIM);
        end
    end

    // scan high to low so the lowest eligible ID is the one left standing
    always_comb begin
        gnt    = '0;
        win_id = REQ_PLAYER;
        aged   = |aged_vec;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (aged ? aged_vec[i] : req[i]) begin
                gnt    = '0;
                gnt[i] = 1'b1;
                win_id = req_id_t'(i[1:0]);
            end
        end
    end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Sprite ROM arbiter: shares one palette-index ROM among player, plane and
// missile address generators, adds per-requester base offsets and returns the
// palette index tagged with the requester ID after 1 + ROM_LAT cycles.
// Optional per-requester grant statistics: define SPRITE_ARB_STATS_EN.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   ST_IDLE  | nothing pending; a new request is granted and moves to RUN
//   ST_RUN   | arbitrating; returns to IDLE when req==0 and the pipe is empty
//   ST_FLUSH | ROM_LAT+1 cycles, no grants, in-flight reads discarded
module sprite_rom_arbiter
    import slug_arb_pkg::*;
#(
    parameter int ROM_LAT = 1,
    parameter int AGE_MAX = 7,
    parameter int BASE0   = 0,
    parameter int BASE1   = 1500,
    parameter int BASE2   = 1700,
    parameter int ADDR_W  = 16
) (
    input  logic                Clk,
    input  logic                Reset_n,
    input  logic                frame_start,
    sprite_rom_arbiter_if.slave bus,
    output logic                busy
`ifdef SPRITE_ARB_STATS_EN
    ,
    output logic [15:0]         stat_gnt0,
    output logic [15:0]         stat_gnt1,
    output logic [15:0]         stat_gnt2,
    output logic [15:0]         stat_aged
`endif
);

    localparam logic [ADDR_W-1:0] BASE0_L    = ADDR_W'(BASE0);
    localparam logic [ADDR_W-1:0] BASE1_L    = ADDR_W'(BASE1);
    localparam logic [ADDR_W-1:0] BASE2_L    = ADDR_W'(BASE2);
    localparam logic [1:0]        FLUSH_LOAD = 2'(ROM_LAT);

    arb_state_t                   state_q, state_d;
    logic [1:0]                   flush_cnt_q, flush_cnt_d;
    logic [NUM_REQ-1:0][AGE_W-1:0] age_q, age_d;
    logic [ROM_LAT-1:0]           pipe_vld_q, pipe_vld_d;
    req_id_t                      pipe_id_q [ROM_LAT];
    req_id_t                      pipe_id_d [ROM_LAT];
    logic [ADDR_W-1:0]            rom_addr_q, rom_addr_d;
    rsp_t                         rsp_q, rsp_d;

    logic [NUM_REQ-1:0] pick_gnt;
    logic [NUM_REQ-1:0] gnt;
    req_id_t            win_id;
    logic               pick_aged;
    logic               gnt_en;
    logic [ADDR_W-1:0]  sel_addr;
    logic [ADDR_W-1:0]  sel_base;

    sprite_arb_pick #(
        .AGE_MAX (AGE_MAX)
    ) u_pick (
        .req    (bus.req),
        .age    (age_q),
        .gnt    (pick_gnt),
        .win_id (win_id),
        .aged   (pick_aged)
    );

    // grants are held off in reset, during FLUSH and in the frame_start cycle
    // itself, so nothing is granted whose response would be thrown away
    always_comb begin
        gnt_en = Reset_n && (state_q != ST_FLUSH) && !frame_start;
        gnt    = gnt_en ? pick_gnt : '0;
    end

    // winner's address and base offset
    always_comb begin
        sel_addr = bus.req_addr[ADDR_W-1:0];
        sel_base = BASE0_L;
        case (win_id)
            REQ_PLANE: begin
                sel_addr = bus.req_addr[2*ADDR_W-1:ADDR_W];
                sel_base = BASE1_L;
            end
            REQ_MISSILE: begin
                sel_addr = bus.req_addr[3*ADDR_W-1:2*ADDR_W];
                sel_base = BASE2_L;
            end
            default: ;
        endcase
    end

    // FSM next state and flush down-counter
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        if (frame_start) begin
            state_d     = ST_FLUSH;
            flush_cnt_d = FLUSH_LOAD;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|bus.req) state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (!(|bus.req) && !(|pipe_vld_q)) state_d = ST_IDLE;
                end
                ST_FLUSH: begin
                    if (flush_cnt_q == 2'd0) state_d = ST_IDLE;
                    else                     flush_cnt_d = flush_cnt_q - 2'd1;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // saturating wait counters; reset by a grant, a dropped request or frame_start
    always_comb begin
        age_d = age_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (frame_start || !bus.req[i] || gnt[i])
                age_d[i] = '0;
            else if (age_q[i] != {AGE_W{1'b1}})
                age_d[i] = age_q[i] + AGE_W'(1);
        end
    end

    // ROM address register and in-flight tag pipe
    always_comb begin
        rom_addr_d = (|gnt) ? (sel_addr + sel_base) : rom_addr_q;
        pipe_vld_d = pipe_vld_q;
        pipe_id_d  = pipe_id_q;
        if (frame_start || state_q == ST_FLUSH) begin
            pipe_vld_d = '0;
        end else begin
            pipe_vld_d[0] = |gnt;
            pipe_id_d[0]  = win_id;
            for (int i = 1; i < ROM_LAT; i++) begin
                pipe_vld_d[i] = pipe_vld_q[i-1];
                pipe_id_d[i]  = pipe_id_q[i-1];
            end
        end
    end

    // response register; id and index hold between strobes
    always_comb begin
        rsp_d       = rsp_q;
        rsp_d.valid = 1'b0;
        if (pipe_vld_q[ROM_LAT-1] && !frame_start && state_q != ST_FLUSH) begin
            rsp_d.valid = 1'b1;
            rsp_d.id    = pipe_id_q[ROM_LAT-1];
            rsp_d.index = bus.rom_data;
        end
    end

    // state registers
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= ST_IDLE;
            flush_cnt_q <= 2'd0;
            age_q       <= '0;
            pipe_vld_q  <= '0;
            for (int i = 0; i < ROM_LAT; i++) pipe_id_q[i] <= REQ_PLAYER;
            rom_addr_q  <= '0;
            rsp_q       <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            age_q       <= age_d;
            pipe_vld_q  <= pipe_vld_d;
            pipe_id_q   <= pipe_id_d;
            rom_addr_q  <= rom_addr_d;
            rsp_q       <= rsp_d;
        end
    end

    assign bus.gnt       = gnt;
    assign bus.rom_addr  = rom_addr_q;
    assign bus.rsp_valid = rsp_q.valid;
    assign bus.rsp_id    = rsp_q.id;
    assign bus.rsp_index = rsp_q.index;
    assign busy          = (state_q != ST_IDLE) || (|pipe_vld_q);

`ifdef SPRITE_ARB_STATS_EN
    logic [NUM_REQ-1:0][15:0] stat_gnt_q, stat_gnt_d;
    logic [15:0]              stat_aged_q, stat_aged_d;

    // saturating grant counters; per-requester counts restart each frame
    always_comb begin
        stat_gnt_d  = stat_gnt_q;
        stat_aged_d = stat_aged_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (frame_start)
                stat_gnt_d[i] = '0;
            else if (gnt[i] && stat_gnt_q[i] != 16'hFFFF)
                stat_gnt_d[i] = stat_gnt_q[i] + 16'd1;
        end
        if ((|gnt) && pick_aged && stat_aged_q != 16'hFFFF)
            stat_aged_d = stat_aged_q + 16'd1;
    end

    // statistics registers
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            stat_gnt_q  <= '0;
            stat_aged_q <= '0;
        end else begin
            stat_gnt_q  <= stat_gnt_d;
            stat_aged_q <= stat_aged_d;
        end
    end

    assign stat_gnt0 = stat_gnt_q[0];
    assign stat_gnt1 = stat_gnt_q[1];
    assign stat_gnt2 = stat_gnt_q[2];
    assign stat_aged = stat_aged_q;
`else
    logic unused_aged;
    assign unused_aged = pick_aged;
`endif

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench for sprite_rom_arbiter (default parameters, ROM_LAT=1).
// ROM model: combinational read, contents = a[4:0] ^ a[9:5] ^ 3.
module tb_sprite_rom_arbiter;

    logic Clk = 1'b0;
    logic Reset_n;
    logic frame_start;
    logic busy;
    int   n_chk = 0;
    int   n_bad = 0;
    int   stray;

`ifdef SPRITE_ARB_STATS_EN
    logic [15:0] stat_gnt0, stat_gnt1, stat_gnt2, stat_aged;
`endif

    always #5 Clk = ~Clk;

    sprite_rom_arbiter_if #(.ADDR_W(16)) bus ();

    sprite_rom_arbiter dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .frame_start (frame_start),
        .bus         (bus),
        .busy        (busy)
`ifdef SPRITE_ARB_STATS_EN
        ,
        .stat_gnt0   (stat_gnt0),
        .stat_gnt1   (stat_gnt1),
        .stat_gnt2   (stat_gnt2),
        .stat_aged   (stat_aged)
`endif
    );

    function automatic logic [4:0] rom_f(input logic [15:0] a);
        return a[4:0] ^ a[9:5] ^ 5'd3;
    endfunction

    assign bus.rom_data = rom_f(bus.rom_addr);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_req(input logic [2:0] r, input logic [15:0] a0,
                           input logic [15:0] a1, input logic [15:0] a2);
        bus.req      = r;
        bus.req_addr = {a2, a1, a0};
    endtask

    // req=111 held from all-zero ages, AGE_MAX=7: age1 and age2 both hit 7
    // in cycle 7, the lower ID (1) wins, then missile wins on age 8; after that
    // the period is 8 cycles: six player grants, plane, missile
    function automatic logic [31:0] exp_age_gnt(input int c);
        int m;
        if (c < 7)  return 32'd1;
        if (c == 7) return 32'd2;
        if (c == 8) return 32'd4;
        m = (c - 9) % 8;
        if (m < 6)  return 32'd1;
        if (m == 6) return 32'd2;
        return 32'd4;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset_n     = 1'b0;
        frame_start = 1'b0;
        set_req(3'b001, 16'd0, 16'd0, 16'd0);
        #12;
        chk("rst_gnt",       32'(bus.gnt),       32'd0);
        chk("rst_rom_addr",  32'(bus.rom_addr),  32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_id",    32'(bus.rsp_id),    32'd0);
        chk("rst_rsp_index", 32'(bus.rsp_index), 32'd0);
        chk("rst_busy",      32'(busy),          32'd0);
        set_req(3'b000, 16'd0, 16'd0, 16'd0);
        tick();
        Reset_n = 1'b1;
        tick();
        tick();

        // single request
        tick(); set_req(3'b001, 16'd42, 16'd0, 16'd0); #3;
        chk("single_gnt", 32'(bus.gnt), 32'd1);
        tick(); set_req(3'b000, 16'd0, 16'd0, 16'd0); #3;
        chk("single_rom_addr", 32'(bus.rom_addr), 32'd42);
        chk("single_busy",     32'(busy),         32'd1);
        chk("single_rsp_early", 32'(bus.rsp_valid), 32'd0);
        tick(); #3;
        chk("single_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("single_rsp_id",    32'(bus.rsp_id),    32'd0);
        chk("single_rsp_index", 32'(bus.rsp_index), 32'(rom_f(16'd42)));
        tick(); #3;
        chk("single_rsp_pulse", 32'(bus.rsp_valid), 32'd0);

        // offsets and wrap
        tick(); set_req(3'b010, 16'd0, 16'd10, 16'd0); #3;
        chk("plane_gnt", 32'(bus.gnt), 32'd2);
        tick(); set_req(3'b000, 16'd0, 16'd0, 16'd0); #3;
        chk("plane_offset", 32'(bus.rom_addr), 32'd1510);
        tick(); set_req(3'b010, 16'd0, 16'hFFFF, 16'd0); #3;
        tick(); set_req(3'b000, 16'd0, 16'd0, 16'd0); #3;
        chk("plane_wrap", 32'(bus.rom_addr), 32'd1499);
        tick(); set_req(3'b100, 16'd0, 16'd0, 16'd100); #3;
        chk("missile_gnt", 32'(bus.gnt), 32'd4);
        tick(); set_req(3'b000, 16'd0, 16'd0, 16'd0); #3;
        chk("missile_offset", 32'(bus.rom_addr), 32'd1800);
        tick(); tick(); tick();

        // contention with aging
        for (int c = 0; c < 17; c++) begin
            tick(); set_req(3'b111, 16'd1, 16'd2, 16'd3); #3;
            chk($sformatf("age_gnt%0d", c), 32'(bus.gnt), exp_age_gnt(c));
        end
        tick(); set_req(3'b000, 16'd0, 16'd0, 16'd0);
        tick(); tick(); tick(); #3;
        chk("age_drain_busy", 32'(busy), 32'd0);

        // back-to-back throughput
        for (int k = 0; k < 8; k++) begin
            tick();
            if (k < 5) set_req(3'b010, 16'd0, 16'(k), 16'd0);
            else       set_req(3'b000, 16'd0, 16'd0, 16'd0);
            #3;
            if (k < 5) chk($sformatf("b2b_gnt%0d", k), 32'(bus.gnt), 32'd2);
            if (k >= 2 && k < 7) begin
                chk($sformatf("b2b_vld%0d", k - 2), 32'(bus.rsp_valid), 32'd1);
                chk($sformatf("b2b_id%0d", k - 2),  32'(bus.rsp_id),    32'd1);
                chk($sformatf("b2b_idx%0d", k - 2), 32'(bus.rsp_index),
                    32'(rom_f(16'(1500 + k - 2))));
            end
            if (k == 7) begin
                chk("b2b_vld_end",  32'(bus.rsp_valid), 32'd0);
                chk("b2b_id_hold",  32'(bus.rsp_id),    32'd1);
                chk("b2b_idx_hold", 32'(bus.rsp_index), 32'(rom_f(16'd1504)));
            end
        end
        tick(); tick(); tick();

        // flush one cycle after a grant
        tick(); set_req(3'b001, 16'd5, 16'd0, 16'd0); #3;
        chk("flush_pre_gnt", 32'(bus.gnt), 32'd1);
        tick(); set_req(3'b100, 16'd0, 16'd0, 16'd9); frame_start = 1'b1; #3;
        chk("flush_fs_gnt", 32'(bus.gnt), 32'd0);
        tick(); frame_start = 1'b0; #3;
        chk("flush_gnt_a", 32'(bus.gnt),       32'd0);
        chk("flush_rsp_a", 32'(bus.rsp_valid), 32'd0);
        chk("flush_busy",  32'(busy),          32'd1);
        tick(); #3;
        chk("flush_gnt_b", 32'(bus.gnt),       32'd0);
        chk("flush_rsp_b", 32'(bus.rsp_valid), 32'd0);
        tick(); #3;
        chk("flush_post_gnt",  32'(bus.gnt), 32'd4);
        chk("flush_post_busy", 32'(busy),    32'd0);
        tick(); set_req(3'b000, 16'd0, 16'd0, 16'd0); #3;
        chk("flush_post_addr", 32'(bus.rom_addr), 32'd1709);
        tick(); #3;
        chk("flush_post_vld", 32'(bus.rsp_valid), 32'd1);
        chk("flush_post_id",  32'(bus.rsp_id),    32'd2);
        chk("flush_post_idx", 32'(bus.rsp_index), 32'(rom_f(16'd1709)));

        // async reset with a read in flight
        tick(); set_req(3'b001, 16'd7, 16'd0, 16'd0);
        tick(); set_req(3'b000, 16'd0, 16'd0, 16'd0);
        #3;
        Reset_n = 1'b0;
        #1;
        chk("arst_rom_addr",  32'(bus.rom_addr),  32'd0);
        chk("arst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("arst_rsp_id",    32'(bus.rsp_id),    32'd0);
        chk("arst_rsp_index", 32'(bus.rsp_index), 32'd0);
        chk("arst_busy",      32'(busy),          32'd0);
        chk("arst_gnt",       32'(bus.gnt),       32'd0);
        #3;
        Reset_n = 1'b1;
        stray = 0;
        for (int k = 0; k < 4; k++) begin
            tick(); #3;
            if (bus.rsp_valid) stray++;
        end
        chk("arst_no_stray", 32'(stray),        32'd0);
        chk("arst_addr_hold", 32'(bus.rom_addr), 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
